// File: rtl/control_barrido_displays.sv
// Multiplexed scan of the four Nexys2 seven-segment digits with a frame-synchronous
// shadow register, leading-zero blanking and per-digit decimal points.
module control_barrido_displays #(
  parameter int PRESCALE = 50000
) (
  input  logic        clkNexys2,
  input  logic        Reset,
  input  logic        Habilitacion,
  input  logic [15:0] valor,
  input  logic [3:0]  puntos,
  input  logic        supresionCeros,
  input  logic        cargaReq,
  output logic        cargaAck,
  output logic [3:0]  anodoDisplay,
  output logic [3:0]  digito,
  output logic        habDecod,
  output logic        puntoDisplay,
  output logic        finTrama
);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic {APAGADO, ESCANEO} estado_t;

  estado_t       state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_q, sh_d;
  logic [3:0]    pts_q, pts_d;
  logic          ack_q, ack_d, fin_q, fin_d;
  logic [3:0]    an_q, an_d, dig_q, dig_d;
  logic          hd_q, hd_d, pt_q, pt_d;

  logic        tick, borde, carga, blank;
  logic [15:0] sh_sr;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pts_d   = pts_q;

    tick  = (state_q == ESCANEO) && (pre_q == PMAX);
    borde = tick && (idx_q == 2'd3);
    // In APAGADO there is no frame to tear, so a request is served immediately.
    carga = cargaReq && ((state_q == APAGADO) || borde);

    case (state_q)
      APAGADO: begin
        pre_d = '0;
        idx_d = 2'd0;
        if (Habilitacion) state_d = ESCANEO;
      end
      default: begin
        if (!Habilitacion) begin
          state_d = APAGADO;
          pre_d   = '0;
          idx_d   = 2'd0;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          idx_d = tick ? idx_q + 2'd1 : idx_q;
        end
      end
    endcase

    if (carga) begin
      sh_d  = valor;
      pts_d = puntos;
    end
    ack_d = carga;
    fin_d = borde;

    // Digit i is blank when every nibble from i upward is zero; digit 0 never blanks.
    sh_sr = sh_q >> {idx_q, 2'b00};
    blank = supresionCeros && (idx_q != 2'd0) && (sh_sr == 16'h0000);

    an_d  = 4'b1111;
    dig_d = 4'h0;
    hd_d  = 1'b0;
    pt_d  = 1'b1;
    if (state_q == ESCANEO) begin
      dig_d = sh_sr[3:0];
      if (!blank) begin
        an_d = ~(4'b0001 << idx_q);
        hd_d = 1'b1;
        pt_d = ~pts_q[idx_q];
      end
    end
  end

  always_ff @(posedge clkNexys2) begin
    if (Reset) begin
      state_q <= APAGADO;
      pre_q   <= '0;
      idx_q   <= 2'd0;
      sh_q    <= 16'h0000;
      pts_q   <= 4'b0000;
      ack_q   <= 1'b0;
      fin_q   <= 1'b0;
      an_q    <= 4'b1111;
      dig_q   <= 4'h0;
      hd_q    <= 1'b0;
      pt_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pts_q   <= pts_d;
      ack_q   <= ack_d;
      fin_q   <= fin_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
      hd_q    <= hd_d;
      pt_q    <= pt_d;
    end
  end

  assign cargaAck     = ack_q;
  assign finTrama     = fin_q;
  assign anodoDisplay = an_q;
  assign digito       = dig_q;
  assign habDecod     = hd_q;
  assign puntoDisplay = pt_q;
endmodule

// File: tb/tb_control_barrido_displays.sv
// Randomized plus directed bench for control_barrido_displays against a frame-position model.
module tb_control_barrido_displays;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst, hab, supr, req;
  logic [15:0] valor;
  logic [3:0]  puntos;
  logic        ack, fin, hd, pto;
  logic [3:0]  an, dig;

  int total = 0;
  int bad   = 0;

  // model: whether scanning, position inside the 4*P-cycle frame, shadow contents
  bit          m_on;
  int          m_pos;
  logic [15:0] m_sh;
  logic [3:0]  m_pt;

  control_barrido_displays #(.PRESCALE(P)) dut (
    .clkNexys2(clk), .Reset(rst), .Habilitacion(hab), .valor(valor), .puntos(puntos),
    .supresionCeros(supr), .cargaReq(req), .cargaAck(ack), .anodoDisplay(an),
    .digito(dig), .habDecod(hd), .puntoDisplay(pto), .finTrama(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ciclo();
    logic [3:0] e_an, e_dig;
    logic       e_hd, e_pt, e_ack, e_fin, blank, bnd, ld;
    int         slot;
    ld = 1'b0;
    if (rst) begin
      e_an = 4'hF; e_dig = 4'h0; e_hd = 1'b0; e_pt = 1'b1; e_ack = 1'b0; e_fin = 1'b0;
    end else begin
      slot  = m_pos / P;
      blank = supr && (slot != 0) && ((m_sh >> (4 * slot)) == 0);
      if (m_on && !blank) begin
        e_an = ~(4'b0001 << slot); e_hd = 1'b1; e_pt = ~m_pt[slot];
      end else begin
        e_an = 4'hF; e_hd = 1'b0; e_pt = 1'b1;
      end
      e_dig = m_on ? m_sh[4*slot +: 4] : 4'h0;
      bnd   = m_on && (m_pos == 4*P - 1);
      ld    = req && (!m_on || bnd);
      e_ack = ld;
      e_fin = bnd;
    end
    @(posedge clk); #1;
    chk("anodo", {12'h0, an}, {12'h0, e_an});
    chk("digito", {12'h0, dig}, {12'h0, e_dig});
    chk("habDecod", {15'h0, hd}, {15'h0, e_hd});
    chk("punto", {15'h0, pto}, {15'h0, e_pt});
    chk("ack", {15'h0, ack}, {15'h0, e_ack});
    chk("finTrama", {15'h0, fin}, {15'h0, e_fin});
    if (rst) begin
      m_on = 1'b0; m_pos = 0; m_sh = 16'h0; m_pt = 4'h0;
    end else begin
      if (ld) begin m_sh = valor; m_pt = puntos; end
      if (!m_on) begin m_on = hab; m_pos = 0; end
      else if (!hab) begin m_on = 1'b0; m_pos = 0; end
      else m_pos = (m_pos + 1) % (4*P);
    end
    if (ack) req = 1'b0;
    @(negedge clk);
  endtask

  task automatic corre(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic solicita(input logic [15:0] v, input logic [3:0] p);
    bit done;
    done = 1'b0;
    valor = v; puntos = p; req = 1'b1;
    for (int i = 0; i < 4*P + 4 && !done; i++) begin
      ciclo();
      if (!req) done = 1'b1;
    end
    if (!done) begin
      chk("ack_timeout", 16'h0, 16'h1);
      req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; hab = 1'b0; supr = 1'b0; req = 1'b0; valor = 16'h0; puntos = 4'h0;
    m_on = 1'b0; m_pos = 0; m_sh = 16'h0; m_pt = 4'h0;
    @(negedge clk);
    corre(2);
    rst = 1'b0;
    // load while dark, then scan 0x1234
    solicita(16'h1234, 4'b0000);
    hab = 1'b1;
    corre(40);
    // mid-frame request must wait for the frame boundary
    solicita(16'hABCD, 4'b0000);
    corre(20);
    supr = 1'b1;
    solicita(16'h0050, 4'b0000);
    corre(20);
    solicita(16'h0000, 4'b1111);
    corre(20);
    supr = 1'b0;
    solicita(16'h1234, 4'b0100);
    corre(20);
    supr = 1'b1;
    solicita(16'h0003, 4'b0100);
    corre(20);
    // disable during slot 2, load while dark, re-enable
    while (m_pos != 2*P) ciclo();
    hab = 1'b0;
    corre(3);
    solicita(16'h5A5A, 4'b0011);
    hab = 1'b1;
    corre(24);
    // reset at slot 3 with a pending request
    while (m_pos != 3*P + 1) ciclo();
    valor = 16'hBEEF; puntos = 4'hF; req = 1'b1;
    rst = 1'b1;
    ciclo();
    rst = 1'b0; req = 1'b0;
    corre(20);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) hab = ~hab;
      if ($urandom_range(0, 59) == 0) supr = ~supr;
      rst = ($urandom_range(0, 299) == 0);
      if (!req && $urandom_range(0, 7) == 0) begin
        valor  = 16'($urandom >> $urandom_range(0, 31));
        puntos = 4'($urandom);
        req    = 1'b1;
      end
      ciclo();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_barrido_displays.md
Name: control_barrido_displays

Overview:
- Sequences the shared binary-to-hex seven-segment decoder across the four Nexys2 digits.
- Uses a programmable prescaler for digit timing.
- Holds the value to display in a frame-synchronous shadow register, loaded through a req/ack handshake, so a frame never shows two different values.
- Provides leading-zero suppression and per-digit decimal points.
- Sits between the up/down counter (or any 16-bit source) and the decoder, replacing the free-running selector.

Parameters:
- PRESCALE, 50000, clkNexys2 cycles per digit slot (50 MHz / 50000 = 1 kHz per digit, 250 Hz per frame); legal range 2..2^20.

Ports:
- clkNexys2 input 1 system clock, 50 MHz
- Reset input 1 synchronous, active-high reset
- Habilitacion input 1 1 = scan displays, 0 = all digits dark
- valor input 16 value to display; nibble i drives digit i (digit 0 rightmost)
- puntos input 4 decimal-point request per digit, active-high, sampled with valor
- supresionCeros input 1 1 = blank leading zero digits
- cargaReq input 1 request to load valor/puntos into the shadow register
- cargaAck output 1 one-cycle pulse: valor/puntos captured
- anodoDisplay output 4 digit anodes, active-low
- digito output 4 nibble presented to the decoder
- habDecod output 1 decoder enable for the current slot
- puntoDisplay output 1 decimal point, active-low
- finTrama output 1 one-cycle pulse at the end of each complete frame

Behaviour:
- Clock and reset: one clock, clkNexys2; Reset is synchronous, active-high. Reset overrides every other input on the same edge, including mid-frame and mid-handshake.
- Reset values:
  - state = APAGADO, prescaler = 0, idx = 0
  - shadow value = 0x0000, shadow points = 0000
  - anodoDisplay = 1111, digito = 0000, habDecod = 0, puntoDisplay = 1
  - cargaAck = 0, finTrama = 0
- Prescaler:
  - Counts 0..PRESCALE-1 while state = ESCANEO; tick = (count == PRESCALE-1), and the counter then wraps to 0.
  - Held at 0 in APAGADO.
- Digit index idx (2 bits): increments on tick, wrapping 3 -> 0. A tick with idx = 3 is the frame boundary.
- FSM:
  - APAGADO -> ESCANEO when Habilitacion = 1; idx = 0 and prescaler = 0 on entry.
  - ESCANEO -> APAGADO when Habilitacion = 0, effective at the next edge regardless of prescaler or idx.
- Shadow load and handshake:
  - ESCANEO: load valor/puntos and pulse cargaAck only on the frame-boundary tick, and only if cargaReq = 1 on that cycle.
  - APAGADO: load and pulse cargaAck on any cycle with cargaReq = 1.
  - cargaAck lasts exactly one cycle, registered in the same edge as the load.
  - The requester holds cargaReq, valor and puntos stable until it sees cargaAck, then drops cargaReq.
  - cargaReq still high on the cycle after ack is treated as a new request.
  - Worst-case wait is 4*PRESCALE cycles.
- finTrama: one-cycle pulse on every frame-boundary tick in ESCANEO, coincident with any cargaAck.
- Outputs are registered with one cycle latency from the state/idx/shadow they depict.
  - ESCANEO, slot idx = i: anodoDisplay = ~(1 << i), digito = shadow[4i+3:4i], habDecod = 1, puntoDisplay = ~puntosShadow[i].
  - APAGADO: anodoDisplay = 1111, habDecod = 0, puntoDisplay = 1, digito = 0000.
- Leading-zero suppression:
  - With supresionCeros = 1, digit i (i = 1..3) is blank when shadow nibbles 3..i are all zero.
  - Digit 0 is never blanked; shadow 0x0000 shows a single "0".
  - A blank slot drives anodoDisplay = 1111, habDecod = 0, puntoDisplay = 1.
  - A blank slot keeps its time slot, so refresh rate is unchanged.
  - A point request on a blanked digit is suppressed.
- supresionCeros and Habilitacion are used live, not shadowed.

Test Plan:
1. Reset, PRESCALE=4, Habilitacion=1, load 0x1234/puntos=0000 -> after ack, repeating 16-cycle pattern: anodoDisplay 1110/digito 4 (4 cycles), 1101/3, 1011/2, 0111/1; finTrama every 16 cycles; puntoDisplay constant 1.
2. Mid-frame (idx=1) raise cargaReq with 0xABCD -> no ack until frame-boundary tick; then cargaAck and finTrama pulse together; the next frame shows D,C,B,A; previous frame fully 0x1234.
3. supresionCeros=1, load 0x0050 -> slots 3 and 2 show anodoDisplay=1111/habDecod=0; slot 1 digito=5; slot 0 digito=0; load 0x0000 -> only digit 0 lit, showing 0.
4. puntos=0100, value 0x1234 -> puntoDisplay=0 only while anodoDisplay=1011; with supresionCeros=1 and value 0x0003, same puntos -> puntoDisplay stays 1.
5. Habilitacion=0 while idx=2 -> next cycle all anodes 1111 and habDecod=0; cargaReq in APAGADO acked on the next edge; Habilitacion=1 again -> restarts at idx=0 with a full PRESCALE slot.
6. Assert Reset at idx=3 with cargaReq pending -> all outputs at reset values the following cycle, shadow=0x0000, no cargaAck emitted.
